// File: rtl/gf_2to4_inverter_iter.sv
// -----------------------------------------------------------------------------
// gf_2to4_inverter_iter
//   Iterative GF(2^4) multiplicative inverter, inv(a) = a^14, computed by
//   square-and-multiply on one shared combinational gf_2to4_multiplier.
//   Field: composite basis y^2 + y + phi over GF(2^2) (x^2 + x + 1), phi = x.
//
// Ports
//   i_clock  rising-edge clock
//   i_reset  synchronous active-high reset
//   i_valid  operand valid          o_ready  idle, can accept an operand
//   i_data   operand a
//   o_valid  result valid           i_ready  downstream accepts the result
//   o_inv    a^14 (0 when a = 0)    o_zero   accepted operand was 0
//
// Also contains gf_2to4_multiplier (same field representation):
//   i_clock, i_reset  used only when CREATE_OUTPUT_REG = 1
//   i_a, i_b          operands
//   o_prod            i_a * i_b
// -----------------------------------------------------------------------------

module gf_2to4_multiplier #(
   parameter int unsigned NB_DATA           = 4,
   parameter bit          CREATE_OUTPUT_REG = 1'b0
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_DATA-1:0] i_a,
   input  logic [NB_DATA-1:0] i_b,
   output logic [NB_DATA-1:0] o_prod
);

   localparam int unsigned NB_HALF = NB_DATA / 2;

   // GF(2^2) product modulo x^2 + x + 1
   function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
      gf2_mul[1] = (a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]);
      gf2_mul[0] = (a[1] & b[1]) ^ (a[0] & b[0]);
   endfunction

   // Multiply by phi = x: (c1 x + c0) x = (c1 ^ c0) x + c1
   function automatic logic [1:0] gf2_mul_phi(input logic [1:0] c);
      gf2_mul_phi = {c[1] ^ c[0], c[1]};
   endfunction

   logic [NB_HALF-1:0] hh_c;
   logic [NB_DATA-1:0] prod_c;

   // (ah y + al)(bh y + bl) with y^2 = y + phi
   always_comb begin
      hh_c   = gf2_mul(i_a[NB_DATA-1:NB_HALF], i_b[NB_DATA-1:NB_HALF]);
      prod_c = '0;
      prod_c[NB_DATA-1:NB_HALF] = hh_c
                                ^ gf2_mul(i_a[NB_DATA-1:NB_HALF], i_b[NB_HALF-1:0])
                                ^ gf2_mul(i_a[NB_HALF-1:0], i_b[NB_DATA-1:NB_HALF]);
      prod_c[NB_HALF-1:0]       = gf2_mul_phi(hh_c)
                                ^ gf2_mul(i_a[NB_HALF-1:0], i_b[NB_HALF-1:0]);
   end

   generate
      if (CREATE_OUTPUT_REG) begin : g_out_reg
         logic [NB_DATA-1:0] prod_q;
         always_ff @(posedge i_clock) begin
            if (i_reset) prod_q <= '0;
            else         prod_q <= prod_c;
         end
         assign o_prod = prod_q;
      end else begin : g_out_comb
         // clock/reset only matter for the registered variant
         logic unused_clk_rst;
         assign unused_clk_rst = i_clock ^ i_reset;
         assign o_prod = prod_c;
      end
   endgenerate

endmodule

module gf_2to4_inverter_iter #(
   parameter int unsigned NB_DATA      = 4,    // only 4 is meaningful
   parameter bit          FAST_TRIVIAL = 1'b1
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [NB_DATA-1:0]   i_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [NB_DATA-1:0]   o_inv,
   output logic [NB_DATA/4-1:0] o_zero
);

   localparam int unsigned NB_STEP = 3;
   localparam int unsigned NB_ZERO = NB_DATA / 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_BYP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   state_e               state_q;
   logic [NB_STEP-1:0]   step_q;
   logic [NB_DATA-1:0]   a_q;
   logic [NB_DATA-1:0]   sq_q;
   logic [NB_DATA-1:0]   acc_q;
   logic [NB_ZERO-1:0]   zero_pend_q;
   logic                 valid_q;
   logic [NB_DATA-1:0]   inv_q;
   logic [NB_ZERO-1:0]   zero_q;

   logic [NB_DATA-1:0]   mul_a;
   logic [NB_DATA-1:0]   mul_b;
   logic [NB_DATA-1:0]   mul_p;

   // Operand mux for the shared multiplier, one product per MUL step
   always_comb begin
      mul_a = a_q;
      mul_b = a_q;
      case (step_q)
         NB_STEP'(0):              begin mul_a = a_q;   mul_b = a_q;  end
         NB_STEP'(1), NB_STEP'(3): begin mul_a = sq_q;  mul_b = sq_q; end
         NB_STEP'(2), NB_STEP'(4): begin mul_a = acc_q; mul_b = sq_q; end
         default:                  begin mul_a = a_q;   mul_b = a_q;  end
      endcase
   end

   gf_2to4_multiplier #(
      .NB_DATA           (NB_DATA),
      .CREATE_OUTPUT_REG (1'b0)
   ) u_mul (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_a     (mul_a),
      .i_b     (mul_b),
      .o_prod  (mul_p)
   );

   // Control FSM and datapath registers. The zero flag is captured at accept
   // but published together with the result so o_inv/o_zero move as a pair.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         a_q         <= '0;
         sq_q        <= '0;
         acc_q       <= '0;
         zero_pend_q <= '0;
         valid_q     <= 1'b0;
         inv_q       <= '0;
         zero_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  a_q         <= i_data;
                  zero_pend_q <= NB_ZERO'(i_data == '0);
                  step_q      <= '0;
                  if (FAST_TRIVIAL && (i_data <= NB_DATA'(1))) state_q <= ST_BYP;
                  else                                         state_q <= ST_MUL;
               end
            end
            ST_MUL: begin
               step_q <= step_q + NB_STEP'(1);
               case (step_q)
                  NB_STEP'(0): begin sq_q <= mul_p; acc_q <= mul_p; end  // a^2
                  NB_STEP'(1): sq_q  <= mul_p;                           // a^4
                  NB_STEP'(2): acc_q <= mul_p;                           // a^6
                  NB_STEP'(3): sq_q  <= mul_p;                           // a^8
                  NB_STEP'(4): begin                                     // a^14
                     acc_q   <= mul_p;
                     inv_q   <= mul_p;
                     zero_q  <= zero_pend_q;
                     valid_q <= 1'b1;
                     state_q <= ST_DONE;
                  end
                  default: state_q <= ST_IDLE;
               endcase
            end
            ST_BYP: begin
               // 0 and 1 are their own "inverse"
               acc_q   <= a_q;
               inv_q   <= a_q;
               zero_q  <= zero_pend_q;
               valid_q <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (i_ready) begin
                  valid_q <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               valid_q <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready = (state_q == ST_IDLE);
   assign o_valid = valid_q;
   assign o_inv   = inv_q;
   assign o_zero  = zero_q;

endmodule

// File: tb/tb_gf_2to4_inverter_iter.sv
// -----------------------------------------------------------------------------
// tb_gf_2to4_inverter_iter
//   Self-checking bench for gf_2to4_inverter_iter. Two instances: index 0 with
//   FAST_TRIVIAL = 1, index 1 with FAST_TRIVIAL = 0. Expected results come from
//   a behavioural GF(2^4) model (polynomial arithmetic, a^14 by repetition).
// -----------------------------------------------------------------------------

module tb_gf_2to4_inverter_iter;

   logic       clk = 1'b0;
   logic       rst;
   logic       vld   [2];
   logic [3:0] dat   [2];
   logic       rdy   [2];
   logic       ordy  [2];
   logic       oval  [2];
   logic [3:0] oinv  [2];
   logic [0:0] ozero [2];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gf_2to4_inverter_iter #(.NB_DATA(4), .FAST_TRIVIAL(1'b1)) u_fast (
      .i_clock (clk),     .i_reset (rst),
      .i_valid (vld[0]),  .o_ready (ordy[0]),
      .i_data  (dat[0]),  .o_valid (oval[0]),
      .i_ready (rdy[0]),  .o_inv   (oinv[0]),
      .o_zero  (ozero[0])
   );

   gf_2to4_inverter_iter #(.NB_DATA(4), .FAST_TRIVIAL(1'b0)) u_loop (
      .i_clock (clk),     .i_reset (rst),
      .i_valid (vld[1]),  .o_ready (ordy[1]),
      .i_data  (dat[1]),  .o_valid (oval[1]),
      .i_ready (rdy[1]),  .o_inv   (oinv[1]),
      .o_zero  (ozero[1])
   );

   // GF(2^2): polynomial product reduced by x^2 + x + 1
   function automatic logic [1:0] m2(input logic [1:0] x, input logic [1:0] y);
      logic [2:0] p;
      p = '0;
      for (int i = 0; i < 2; i++)
         if (y[i]) p = p ^ (3'({1'b0, x}) << i);
      if (p[2]) p = p ^ 3'b111;
      return p[1:0];
   endfunction

   // GF(2^4) over GF(2^2): y^2 = y + phi, phi = x
   function automatic logic [3:0] m4(input logic [3:0] a, input logic [3:0] b);
      logic [1:0] t, mid, ll;
      t   = m2(a[3:2], b[3:2]);
      mid = m2(a[3:2], b[1:0]) ^ m2(a[1:0], b[3:2]);
      ll  = m2(a[1:0], b[1:0]);
      return {t ^ mid, m2(t, 2'b10) ^ ll};
   endfunction

   function automatic logic [3:0] pow14(input logic [3:0] a);
      logic [3:0] r;
      r = 4'h1;
      for (int i = 0; i < 14; i++) r = m4(r, a);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One operand through instance k; ready held low for 'hold' cycles in DONE
   task automatic run_op(input int k, input logic [3:0] a, input int hold);
      int         lat;
      int         exp_lat;
      logic [3:0] exp_inv;
      exp_inv = pow14(a);
      exp_lat = (k == 0 && a <= 4'd1) ? 1 : 5;
      check($sformatf("ready_idle k%0d a%0h", k, a), 32'(ordy[k]), 32'd1);
      rdy[k] = (hold == 0);
      vld[k] = 1'b1;
      dat[k] = a;
      @(posedge clk); #1;
      vld[k] = 1'b0;
      dat[k] = 4'($urandom);
      check($sformatf("busy_after_accept k%0d a%0h", k, a), 32'({oval[k], ordy[k]}), 32'd0);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (oval[k]) begin
            lat = c;
            break;
         end
      end
      check($sformatf("latency k%0d a%0h", k, a), 32'(lat), 32'(exp_lat));
      check($sformatf("inv k%0d a%0h", k, a), 32'(oinv[k]), 32'(exp_inv));
      if (a != 4'h0)
         check($sformatf("a_times_inv k%0d a%0h", k, a), 32'(m4(a, oinv[k])), 32'h1);
      check($sformatf("zero k%0d a%0h", k, a), 32'(ozero[k]), 32'(a == 4'h0));
      for (int h = 0; h < hold; h++) begin
         vld[k] = 1'($urandom);
         dat[k] = 4'($urandom);
         @(posedge clk); #1;
         check($sformatf("hold_valid k%0d a%0h", k, a), 32'(oval[k]), 32'd1);
         check($sformatf("hold_inv k%0d a%0h", k, a), 32'(oinv[k]), 32'(exp_inv));
         check($sformatf("hold_ready k%0d a%0h", k, a), 32'(ordy[k]), 32'd0);
      end
      vld[k] = 1'b0;
      rdy[k] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("release_valid k%0d a%0h", k, a), 32'(oval[k]), 32'd0);
      check($sformatf("release_ready k%0d a%0h", k, a), 32'(ordy[k]), 32'd1);
      check($sformatf("release_inv_held k%0d a%0h", k, a), 32'(oinv[k]), 32'(exp_inv));
   endtask

   initial begin : watchdog
      #200us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int         nacc, nres, cyc;
      int         acc_cyc [8];
      bit         take, seen;
      logic [3:0] ra;

      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         vld[k] = 1'b0; dat[k] = 4'h0; rdy[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check($sformatf("rst_valid k%0d", k), 32'(oval[k]), 32'd0);
         check($sformatf("rst_inv k%0d", k), 32'(oinv[k]), 32'd0);
         check($sformatf("rst_zero k%0d", k), 32'(ozero[k]), 32'd0);
         check($sformatf("rst_ready k%0d", k), 32'(ordy[k]), 32'd1);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Trivial operands on both paths, then exhaustive sweep
      for (int k = 0; k < 2; k++)
         for (int a = 0; a < 16; a++)
            run_op(k, 4'(a), 0);

      // Backpressure with ignored valid pulses, loop and bypass paths
      run_op(1, 4'hb, 10);
      run_op(0, 4'h1, 4);
      run_op(0, 4'h6, 3);

      // Reset at step 2 of a = 7 discards the partial result
      vld[1] = 1'b1; dat[1] = 4'h7;
      @(posedge clk); #1;
      vld[1] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_valid", 32'(oval[1]), 32'd0);
      check("midrst_inv", 32'(oinv[1]), 32'd0);
      check("midrst_zero", 32'(ozero[1]), 32'd0);
      check("midrst_ready", 32'(ordy[1]), 32'd1);
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (oval[1]) seen = 1'b1;
      end
      check("midrst_no_valid_pulse", 32'(seen), 32'd0);
      run_op(1, 4'h7, 0);

      // Random operands, random instance and backpressure
      repeat (16) begin
         ra = 4'($urandom);
         run_op(int'($urandom_range(0, 1)), ra, int'($urandom_range(0, 3)));
      end

      // Back-to-back on the loop instance, valid and ready tied high
      nacc = 0; nres = 0; cyc = 0;
      rdy[1] = 1'b1; vld[1] = 1'b1; dat[1] = 4'h2;
      repeat (70) begin
         take = ordy[1] && vld[1];
         @(posedge clk); #1;
         cyc++;
         if (take) begin
            if (nacc < 8) acc_cyc[nacc] = cyc;
            nacc++;
            if (nacc < 8) dat[1] = 4'(2 + nacc);
            else          vld[1] = 1'b0;
         end
         if (oval[1]) begin
            if (nres < 8) begin
               check($sformatf("b2b_inv #%0d", nres), 32'(oinv[1]), 32'(pow14(4'(2 + nres))));
               check($sformatf("b2b_lat #%0d", nres), 32'(cyc - acc_cyc[nres]), 32'd5);
            end
            nres++;
         end
      end
      check("b2b_accepts", 32'(nacc), 32'd8);
      check("b2b_results", 32'(nres), 32'd8);
      for (int i = 1; i < 8; i++)
         check($sformatf("b2b_gap #%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
